// File: rtl/pipelined_adder_substractor.sv
// Pipelined BITS-wide adder/subtractor: one carry-chain slice per stage, ADC/SBC carry-in,
// optional signed saturation, NZCV flags and a valid/ready handshake on both sides.
module pipelined_adder_substractor #(
    parameter int unsigned BITS   = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [BITS-1:0] bus_a_i,
    input  logic [BITS-1:0] bus_b_i,
    input  logic [1:0]      op_i,
    input  logic            carry_i,
    input  logic            sat_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [BITS-1:0] sum_o,
    output logic            flag_n_o,
    output logic            flag_z_o,
    output logic            flag_c_o,
    output logic            flag_v_o
);

    localparam int unsigned SW  = BITS / STAGES;
    localparam int unsigned TOP = STAGES - 1;

    if ((STAGES == 0) || (STAGES > BITS) || ((BITS % STAGES) != 0)) begin : g_param_check
        $error("BITS must be a non-zero multiple of STAGES with 1 <= STAGES <= BITS");
    end

    logic advance;

    // Stage inputs: index 0 is the prepared operand set, index k is stage k-1's register.
    logic [BITS-1:0] a_in   [STAGES];
    logic [BITS-1:0] b_in   [STAGES];
    logic [BITS-1:0] r_in   [STAGES];
    logic            c_in   [STAGES];
    logic            s_in   [STAGES];
    logic            v_in   [STAGES];

    logic [BITS-1:0] a_q    [STAGES];
    logic [BITS-1:0] b_q    [STAGES];
    logic [BITS-1:0] r_q    [STAGES];
    logic            c_q    [STAGES];
    logic            s_q    [STAGES];
    logic            v_q    [STAGES];

    logic [BITS-1:0] r_d    [STAGES];
    logic            co_d   [STAGES];

    logic [BITS-1:0] raw;
    logic [BITS-1:0] sum_d;
    logic            a_msb;
    logic            b_msb;
    logic            ovf;

    logic [BITS-1:0] sum_q;
    logic            flag_n_q;
    logic            flag_z_q;
    logic            flag_c_q;
    logic            flag_v_q;

    assign valid_o = v_q[TOP];
    assign advance = !valid_o || ready_i;
    assign ready_o = advance;

    always_comb begin
        a_in[0] = bus_a_i;
        b_in[0] = op_i[0] ? ~bus_b_i : bus_b_i;
        // ADD -> 0, SUB -> 1, ADC/SBC -> carry_i
        c_in[0] = op_i[1] ? carry_i : op_i[0];
        s_in[0] = sat_i;
        v_in[0] = valid_i;
        r_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            r_in[k] = r_q[k-1];
            c_in[k] = c_q[k-1];
            s_in[k] = s_q[k-1];
            v_in[k] = v_q[k-1];
        end
    end

    always_comb begin
        logic [SW:0] slice;
        slice = '0;
        for (int k = 0; k < STAGES; k++) begin
            slice = {1'b0, a_in[k][k*SW +: SW]} + {1'b0, b_in[k][k*SW +: SW]}
                  + {{SW{1'b0}}, c_in[k]};
            r_d[k]               = r_in[k];
            r_d[k][k*SW +: SW]   = slice[SW-1:0];
            co_d[k]              = slice[SW];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
                c_q[k] <= 1'b0;
                s_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                r_q[k] <= r_d[k];
                c_q[k] <= co_d[k];
                s_q[k] <= s_in[k];
                v_q[k] <= v_in[k];
            end
        end
    end

    // Final slice result, overflow and saturation are resolved before the output register.
    always_comb begin
        raw   = r_d[TOP];
        a_msb = a_in[TOP][BITS-1];
        b_msb = b_in[TOP][BITS-1];
        ovf   = (a_msb == b_msb) && (raw[BITS-1] != a_msb);
        sum_d = raw;
        if (s_in[TOP] && ovf) begin
            sum_d = a_msb ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sum_q    <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else if (advance) begin
            sum_q    <= sum_d;
            flag_n_q <= sum_d[BITS-1];
            flag_z_q <= (sum_d == '0);
            flag_c_q <= co_d[TOP];
            flag_v_q <= ovf;
        end
    end

    assign sum_o    = sum_q;
    assign flag_n_o = flag_n_q;
    assign flag_z_o = flag_z_q;
    assign flag_c_o = flag_c_q;
    assign flag_v_o = flag_v_q;

endmodule

// File: tb/tb_pipelined_adder_substractor.sv
// Directed bench for pipelined_adder_substractor in three shapes: 8/4, 32/1 and 16/16.
module tb_pipelined_adder_substractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    int          sel;
    logic        valid_in;
    logic        ready_in;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic [1:0]  op_in;
    logic        carry_in;
    logic        sat_in;

    logic        rdy8,  vo8,  n8,  z8,  c8,  v8;
    logic        rdy32, vo32, n32, z32, c32, v32;
    logic        rdy16, vo16, n16, z16, c16, v16;
    logic [7:0]  sum8;
    logic [31:0] sum32;
    logic [15:0] sum16;

    logic        out_ready;
    logic        out_valid;
    logic [63:0] out_sum;
    logic [3:0]  out_flags;

    pipelined_adder_substractor #(.BITS(8), .STAGES(4)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_in && (sel == 0)), .ready_o(rdy8),
        .bus_a_i(a_in[7:0]), .bus_b_i(b_in[7:0]), .op_i(op_in), .carry_i(carry_in),
        .sat_i(sat_in), .valid_o(vo8), .ready_i(ready_in || (sel != 0)), .sum_o(sum8),
        .flag_n_o(n8), .flag_z_o(z8), .flag_c_o(c8), .flag_v_o(v8)
    );

    pipelined_adder_substractor #(.BITS(32), .STAGES(1)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_in && (sel == 1)), .ready_o(rdy32),
        .bus_a_i(a_in[31:0]), .bus_b_i(b_in[31:0]), .op_i(op_in), .carry_i(carry_in),
        .sat_i(sat_in), .valid_o(vo32), .ready_i(ready_in || (sel != 1)), .sum_o(sum32),
        .flag_n_o(n32), .flag_z_o(z32), .flag_c_o(c32), .flag_v_o(v32)
    );

    pipelined_adder_substractor #(.BITS(16), .STAGES(16)) dut16 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_in && (sel == 2)), .ready_o(rdy16),
        .bus_a_i(a_in[15:0]), .bus_b_i(b_in[15:0]), .op_i(op_in), .carry_i(carry_in),
        .sat_i(sat_in), .valid_o(vo16), .ready_i(ready_in || (sel != 2)), .sum_o(sum16),
        .flag_n_o(n16), .flag_z_o(z16), .flag_c_o(c16), .flag_v_o(v16)
    );

    always_comb begin
        out_ready = rdy8;
        out_valid = vo8;
        out_sum   = {56'd0, sum8};
        out_flags = {n8, z8, c8, v8};
        if (sel == 1) begin
            out_ready = rdy32;
            out_valid = vo32;
            out_sum   = {32'd0, sum32};
            out_flags = {n32, z32, c32, v32};
        end else if (sel == 2) begin
            out_ready = rdy16;
            out_valid = vo16;
            out_sum   = {48'd0, sum16};
            out_flags = {n16, z16, c16, v16};
        end
    end

    typedef struct {
        logic [63:0] sum;
        logic [3:0]  f;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nfail = 0;
    int   cyc = 0;
    bit   check_lat = 1'b0;

    function automatic int width_of(input int s);
        return (s == 1) ? 32 : (s == 2) ? 16 : 8;
    endfunction

    function automatic int stages_of(input int s);
        return (s == 1) ? 1 : (s == 2) ? 16 : 4;
    endfunction

    // Whole-word reference: returns {N, Z, C, V, sum}.
    function automatic logic [67:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] op, input logic ci, input logic sat);
        logic [63:0] mask, bp, raw, sum;
        logic [64:0] full;
        logic        cin, c, v, as, bs, rs;
        mask = (64'd1 << w) - 64'd1;
        bp   = op[0] ? (~b & mask) : (b & mask);
        cin  = op[1] ? ci : op[0];
        full = {1'b0, a & mask} + {1'b0, bp} + {64'd0, cin};
        raw  = full[63:0] & mask;
        c    = full[w];
        as   = a[w-1];
        bs   = bp[w-1];
        rs   = raw[w-1];
        v    = (as == bs) && (rs != as);
        sum  = (sat && v) ? (as ? (64'd1 << (w - 1)) : (mask >> 1)) : raw;
        return {sum[w-1], (sum == 64'd0), c, v, sum};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: check what is on the outputs, drive new inputs, book-keep the handshake.
    task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op, input logic ci, input logic sat, input logic rdy);
        exp_t        e;
        logic [67:0] m;
        @(negedge clk);
        cyc++;
        if (q.size() == 0) begin
            check("no_stale_valid", 64'(out_valid), 64'd0);
        end else if (out_valid) begin
            check("stream_sum", out_sum, q[0].sum);
            check("stream_flags", 64'(out_flags), 64'(q[0].f));
            if (check_lat) check("latency", 64'(cyc - q[0].acc), 64'(stages_of(sel)));
        end
        ready_in = rdy;
        valid_in = v;
        a_in     = a;
        b_in     = b;
        op_in    = op;
        carry_in = ci;
        sat_in   = sat;
        #1;
        check("ready_o", 64'(out_ready), 64'(!out_valid || rdy));
        if (out_valid && rdy && (q.size() > 0)) void'(q.pop_front());
        if (v && out_ready) begin
            m     = model(width_of(sel), a, b, op, ci, sat);
            e.sum = m[63:0];
            e.f   = m[67:64];
            e.acc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic run_dir(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [1:0] op, input logic ci, input logic sat,
                           input logic [63:0] xs, input logic [3:0] xf);
        int i;
        step(1'b1, a, b, op, ci, sat, 1'b1);
        i = 0;
        while (!out_valid && (i < 40)) begin
            step(1'b0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0, 1'b1);
            i++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_sum"}, out_sum, xs);
        check({tag, "_flags"}, 64'(out_flags), 64'(xf));
    endtask

    // Width-generic forms of the hand-worked 8-bit cases; flags are {N,Z,C,V}.
    task automatic run_all_dir(input int s);
        logic [63:0] mask, maxpos, minneg;
        mask   = (64'd1 << width_of(s)) - 64'd1;
        maxpos = mask >> 1;
        minneg = 64'd1 << (width_of(s) - 1);
        run_dir("add_ovf",     maxpos, 64'd1, 2'b00, 1'b0, 1'b0, minneg, 4'b1001);
        run_dir("add_ovf_sat", maxpos, 64'd1, 2'b00, 1'b0, 1'b1, maxpos, 4'b0001);
        run_dir("sub_borrow",  64'd0,  64'd1, 2'b01, 1'b0, 1'b0, mask,   4'b1000);
        run_dir("sub_zero",    64'd5,  64'd5, 2'b01, 1'b0, 1'b0, 64'd0,  4'b0110);
        run_dir("adc_chain",   mask,   64'd0, 2'b10, 1'b1, 1'b0, 64'd0,  4'b0110);
        run_dir("sbc_sat",     minneg, 64'd1, 2'b11, 1'b1, 1'b1, minneg, 4'b1011);
        run_dir("add_ign_ci",  64'd1,  64'd1, 2'b00, 1'b1, 1'b0, 64'd2,  4'b0000);
        run_dir("adc_ci",      64'd1,  64'd1, 2'b10, 1'b1, 1'b0, 64'd3,  4'b0000);
        run_dir("sbc_noci",    64'h10, 64'd1, 2'b11, 1'b0, 1'b0, 64'h0e, 4'b0010);
    endtask

    task automatic rand_op(input logic rdy);
        step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [63:0] held_sum;
        logic [3:0]  held_flags;

        sel      = 0;
        valid_in = 1'b1;
        ready_in = 1'b0;
        a_in     = 64'h7f;
        b_in     = 64'h01;
        op_in    = 2'b00;
        carry_in = 1'b0;
        sat_in   = 1'b0;

        // Reset held with valid_i asserted: nothing may be captured.
        repeat (3) @(negedge clk);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_sum", out_sum, 64'd0);
        check("reset_flags", 64'(out_flags), 64'd0);
        check("reset_ready", 64'(out_ready), 64'd1);
        rst_n    = 1'b1;
        valid_in = 1'b0;

        check_lat = 1'b1;
        run_all_dir(0);

        for (int i = 0; i < 16; i++) rand_op(1'b1);

        // Downstream stall for 5 cycles with new requests offered.
        check_lat  = 1'b0;
        held_sum   = '0;
        held_flags = '0;
        for (int i = 0; i < 5; i++) begin
            rand_op(1'b0);
            check("stall_valid", 64'(out_valid), 64'd1);
            if (i == 0) begin
                held_sum   = out_sum;
                held_flags = out_flags;
            end else begin
                check("stall_sum_hold", out_sum, held_sum);
                check("stall_flags_hold", 64'(out_flags), 64'(held_flags));
            end
        end
        for (int i = 0; i < 4; i++) rand_op(1'b1);
        idle(8);
        check("drain_empty", 64'(q.size()), 64'd0);

        // Asynchronous reset with three operations in flight.
        check_lat = 1'b1;
        for (int i = 0; i < 3; i++) rand_op(1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", out_sum, 64'd0);
        check("midrst_flags", 64'(out_flags), 64'd0);
        q.delete();
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b1;
        idle(8);
        run_dir("post_rst", 64'h12, 64'h34, 2'b00, 1'b0, 1'b0, 64'h46, 4'b0000);

        sel = 1;
        run_all_dir(1);

        sel = 2;
        run_all_dir(2);
        for (int i = 0; i < 20; i++) rand_op(1'b1);
        idle(20);
        check("drain16_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipelined_adder_substractor.md
Name: pipelined_adder_substractor

Overview:
- Parametrised, pipelined successor to the ALU's combinational adder/subtractor.
- Splits a BITS-wide add/subtract into STAGES carry-chain slices, one slice per cycle.
- Adds carry-in modes (ADC/SBC), optional signed saturation, full NZCV flags and a valid/ready handshake on both sides.
- Sits between the ALU operand mux and the writeback/flag register for wide datapaths where a single-cycle carry chain misses timing.

Parameters:
- BITS, 32, operand and result width; must be an integer multiple of STAGES.
- STAGES, 4, pipeline depth and number of carry slices; each slice is BITS/STAGES bits; 1 <= STAGES <= BITS.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  input operation valid.
- ready_o  out  1  block accepts the input this cycle.
- bus_a_i  in  BITS  operand A.
- bus_b_i  in  BITS  operand B.
- op_i  in  2  operation: 00 ADD (A+B), 01 SUB (A-B), 10 ADC (A+B+carry_i), 11 SBC (A-B-1+carry_i).
- carry_i  in  1  carry-in, used only for ADC/SBC.
- sat_i  in  1  1 = saturate result on signed overflow.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- sum_o  out  BITS  result.
- flag_n_o  out  1  negative: sum_o[BITS-1].
- flag_z_o  out  1  zero: sum_o == 0.
- flag_c_o  out  1  carry out of the MSB of the raw sum; for SUB/SBC, 1 = no borrow.
- flag_v_o  out  1  signed overflow of the raw sum.

Behaviour:
- Reset (rst_n_i low, asynchronous): all stage valid bits, sum_o and all flags go to 0; valid_o = 0.
  - Reset mid-operation discards every in-flight operation. The first valid_o after release comes from an input accepted after release.
- Advance = !valid_o || ready_i. ready_o = advance (purely combinational, no dependence on valid_i).
- When advance = 1, every stage register shifts one step. An input is captured when valid_i && ready_o.
- When advance = 0, all stages hold, including operands, carries and valid bits. Bubbles are not compressed.
- Latency: exactly STAGES cycles from acceptance to valid_o with ready_i held high. Throughput: 1 op/cycle.
- Operand prep at capture:
  - B' = B for ADD/ADC, ~B for SUB/SBC.
  - cin = 0 for ADD, 1 for SUB, carry_i for ADC/SBC.
- Stage k (0..STAGES-1):
  - Computes slice k = A[k] + B'[k] + carry from stage k-1 (cin for k = 0).
  - Registers the slice result and its carry-out.
  - Carries forward the unprocessed upper A/B' slices, sat_i and the sign bits.
- Final stage:
  - raw = concatenated slices.
  - C = carry-out of the top slice.
  - V = (A[MSB] == B'[MSB]) && (raw[MSB] != A[MSB]).
- Saturation (sat_i = 1 and V = 1): sum_o = 0111..1 if A[MSB] = 0, else 1000..0. Otherwise sum_o = raw.
- Flags:
  - N and Z are taken from the final sum_o, i.e. after saturation.
  - C and V always reflect the raw result.
- STAGES = 1 degenerates to a single registered adder: latency 1, same handshake.
- Simultaneous capture and output are allowed every cycle. Output data is held stable while valid_o && !ready_i.
- op_i/carry_i/sat_i values are don't-care when valid_i = 0. The flags and sum of invalid slots are don't-care, but the held output register must not change while stalled.

Test Plan:
- Use BITS=8, STAGES=4 unless stated.
- Reset: hold rst_n_i low, drive valid_i=1 -> valid_o=0, sum_o=0, all flags 0, ready_o=1; release -> first valid_o exactly 4 cycles after first accept.
- ADD 0x7F+0x01, sat_i=0 -> sum 0x80, N=1 Z=0 C=0 V=1. Same with sat_i=1 -> sum 0x7F, N=0 Z=0 C=0 V=1.
- SUB 0x00-0x01 -> sum 0xFF, N=1 Z=0 C=0 V=0. SUB 0x05-0x05 -> sum 0x00, Z=1 C=1 V=0.
- ADC carry chain: 0xFF+0x00+carry_i=1 -> sum 0x00, Z=1 C=1 V=0. SBC 0x80-0x01 with carry_i=1, sat_i=1 -> raw 0x7F with V=1, so sum 0x80, N=1 C=1 V=1.
- Back-to-back stream of 16 random ops with ready_i=1 -> one result per cycle, in order, each matching the reference model. Then hold ready_i=0 for 5 cycles -> sum_o and flags stable, ready_o=0, no input accepted. Release -> stream resumes with no loss or duplication.
- Async reset asserted mid-stream with 3 ops in flight -> outputs clear immediately, no stale result ever appears on valid_o. Repeat the directed cases with BITS=32 STAGES=1 and BITS=16 STAGES=16.
